// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and data access,
// with data priority bounded by a streak limit so a pending fetch is never starved.
module mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_ctrl,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        grant_dm
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);
  state_t state;
  logic [STREAK_W-1:0] streak;
  logic killed, if_done, dm_done, if_pend, pick_dm;
  assign if_pend = if_req & ~if_kill;
  assign pick_dm = dm_req & (~if_pend | (streak != MAX_STREAK));
  // a kill arriving in the DONE cycle still has to swallow the pulse
  assign if_ready = if_done & ~if_kill;
  assign dm_ready = dm_done;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      streak <= '0;
      killed <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_ctrl <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      grant_dm <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dm_req | if_pend) begin
          state <= WAIT;
          mem_req <= 1'b1;
          grant_dm <= pick_dm;
          mem_we <= pick_dm & dm_we;
          mem_addr <= pick_dm ? dm_addr : if_addr;
          mem_wdata <= pick_dm ? dm_wdata : '0;
          mem_ctrl <= pick_dm ? dm_ctrl : 3'b000;
          // pick_dm with a pending fetch implies streak is below the limit, so this saturates
          streak <= (pick_dm & if_pend) ? streak + 1'b1 : '0;
        end
        WAIT: begin
          if (if_kill & ~grant_dm) killed <= 1'b1;
          if (mem_ack) begin
            state <= DONE;
            mem_req <= 1'b0;
            if (grant_dm) begin
              dm_rdata <= mem_rdata;
              dm_done <= 1'b1;
            end else if (~(killed | if_kill)) begin
              if_rdata <= mem_rdata;
              if_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          killed <= 1'b0;
          if_done <= 1'b0;
          dm_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic if_req, if_kill, if_ready, dm_req, dm_we, dm_ready;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [2:0] dm_ctrl, mem_ctrl;
  logic mem_req, mem_we, mem_ack, busy, grant_dm;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int total = 0;
  int bad = 0;
  int lat = 0;
  int cnt = 0;
  logic force_ack = 1'b0;
  logic prev_if = 1'b0;
  logic prev_dm = 1'b0;
  logic [31:0] last_if;
  typedef struct {logic dm; logic [31:0] d;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DATA_STREAK(4), .STREAK_W(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ctrl(dm_ctrl),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .grant_dm(grant_dm)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h40) ? 32'h93 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic dm, input logic [31:0] d);
    exp_t e;
    e.dm = dm;
    e.d = d;
    sb.push_back(e);
  endtask

  // memory: acks L cycles after mem_req rises, data is a function of the address
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_req) begin
        cnt = 0;
        mem_ack = force_ack;
      end else begin
        mem_ack = (cnt == lat) | force_ack;
        cnt++;
      end
      mem_rdata = mdata(mem_addr);
    end
  end

  // scoreboard monitor: every ready pulse must match the oldest expected completion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (if_ready | dm_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready: if_ready=%0b dm_ready=%0b, expected no completion", if_ready, dm_ready);
        end else begin
          e = sb.pop_front();
          if ({dm_ready, if_ready} !== {e.dm, ~e.dm} || (e.dm ? dm_rdata : if_rdata) !== e.d) begin
            bad++;
            $display("FAIL sb_completion: dm_ready=%0b if_ready=%0b data=%h, expected dm=%0b data=%h",
                     dm_ready, if_ready, e.dm ? dm_rdata : if_rdata, e.dm, e.d);
          end
        end
        total++;
        if ((if_ready & prev_if) | (dm_ready & prev_dm)) begin
          bad++;
          $display("FAIL ready_width: ready high two cycles (if=%0b dm=%0b), expected one-cycle pulse", if_ready, dm_ready);
        end
      end
      prev_if = if_ready;
      prev_dm = dm_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    repeat (2) tick;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, if_ready, dm_ready, if_rdata, dm_rdata, busy, grant_dm} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h rdi=%h rdd=%h busy=%0b, expected all 0",
               mem_req, mem_we, mem_addr, if_rdata, dm_rdata, busy);
    end
    reset = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%0b mem_req=%0b, expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_single_fetch;
    lat = 0;
    if_addr = 32'h40;
    if_req = 1'b1;
    push(1'b0, 32'h93);
    tick;
    total++;
    if ({mem_req, mem_we, mem_ctrl, mem_addr} !== {1'b1, 1'b0, 3'b000, 32'h40}) begin
      bad++;
      $display("FAIL fetch_issue: req=%0b we=%0b ctrl=%b addr=%h, expected 1 0 000 00000040", mem_req, mem_we, mem_ctrl, mem_addr);
    end
    tick;
    total++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h93 || mem_we !== 1'b0 || mem_ctrl !== 3'b000) begin
      bad++;
      $display("FAIL fetch_done: if_ready=%0b if_rdata=%h we=%0b ctrl=%b, expected 1 00000093 0 000", if_ready, if_rdata, mem_we, mem_ctrl);
    end
    if_req = 1'b0;
    last_if = 32'h93;
    tick;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL fetch_idle: busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_store;
    lat = 3;
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h100;
    dm_wdata = 32'hDEADBEEF;
    dm_ctrl = 3'b010;
    push(1'b1, mdata(32'h100));
    for (int c = 1; c <= 4; c++) begin
      tick;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, busy, dm_ready} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL store_hold c%0d: req=%0b we=%0b addr=%h wdata=%h ctrl=%b busy=%0b rdy=%0b, expected 1 1 100 deadbeef 010 1 0",
                 c, mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, busy, dm_ready);
      end
    end
    tick;
    total++;
    if (dm_ready !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL store_done: dm_ready=%0b busy=%0b mem_req=%0b, expected 1 1 0", dm_ready, busy, mem_req);
    end
    dm_req = 1'b0;
    dm_we = 1'b0;
    tick;
  endtask

  task automatic test_streak;
    logic [5:0] pat;
    pat = 6'b101111;
    lat = 0;
    dm_addr = 32'h200;
    if_addr = 32'h300;
    dm_req = 1'b1;
    if_req = 1'b1;
    for (int i = 0; i < 6; i++) push(pat[i], pat[i] ? mdata(32'h200) : mdata(32'h300));
    for (int i = 0; i < 6; i++) begin
      tick;
      total++;
      if (mem_req !== 1'b1 || grant_dm !== pat[i]) begin
        bad++;
        $display("FAIL streak_grant #%0d: mem_req=%0b grant_dm=%0b, expected 1 %0b", i, mem_req, grant_dm, pat[i]);
      end
      tick;
      if (i == 5) begin
        dm_req = 1'b0;
        if_req = 1'b0;
      end
      tick;
    end
    last_if = mdata(32'h300);
  endtask

  task automatic test_kill;
    logic [31:0] prior;
    prior = last_if;
    lat = 4;
    if_addr = 32'h400;
    if_req = 1'b1;
    tick;
    tick;
    if_kill = 1'b1;
    if_req = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      tick;
      if_kill = 1'b0;
      total++;
      if (if_ready !== 1'b0) begin
        bad++;
        $display("FAIL kill_ready c%0d: if_ready=%0b, expected 0", c, if_ready);
      end
      if (c == 5) begin
        total++;
        if (mem_req !== 1'b1 || mem_ack !== 1'b1) begin
          bad++;
          $display("FAIL kill_completes: mem_req=%0b mem_ack=%0b, expected 1 1", mem_req, mem_ack);
        end
      end
      if (c == 6) begin
        total++;
        if (busy !== 1'b1 || grant_dm !== 1'b0) begin
          bad++;
          $display("FAIL kill_done: busy=%0b grant_dm=%0b, expected 1 0", busy, grant_dm);
        end
        if_addr = 32'h500;
        if_req = 1'b1;
        lat = 0;
        push(1'b0, mdata(32'h500));
      end
      if (c == 7) begin
        total++;
        if (if_rdata !== prior || busy !== 1'b0) begin
          bad++;
          $display("FAIL kill_rdata: if_rdata=%h busy=%0b, expected %h 0", if_rdata, busy, prior);
        end
      end
    end
    tick;
    total++;
    if (mem_req !== 1'b1 || grant_dm !== 1'b0 || mem_addr !== 32'h500) begin
      bad++;
      $display("FAIL kill_next_fetch: req=%0b grant_dm=%0b addr=%h, expected 1 0 00000500", mem_req, grant_dm, mem_addr);
    end
    tick;
    if_req = 1'b0;
    last_if = mdata(32'h500);
    tick;
    if_addr = 32'h540;
    if_req = 1'b1;
    if_kill = 1'b1;
    tick;
    total++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle_block: busy=%0b mem_req=%0b, expected 0 0", busy, mem_req);
    end
    if_req = 1'b0;
    if_kill = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    lat = 20;
    dm_addr = 32'h600;
    dm_we = 1'b0;
    dm_req = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    dm_req = 1'b0;
    tick;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, if_ready, dm_ready, if_rdata, dm_rdata, busy, grant_dm} !== '0) begin
      bad++;
      $display("FAIL reset_mid: req=%0b addr=%h rdi=%h rdd=%h busy=%0b grant=%0b, expected all 0",
               mem_req, mem_addr, if_rdata, dm_rdata, busy, grant_dm);
    end
    reset = 1'b0;
    last_if = '0;
    force_ack = 1'b1;
    tick;
    tick;
    total++;
    if (dm_ready !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL late_ack: dm_ready=%0b busy=%0b mem_req=%0b, expected 0 0 0", dm_ready, busy, mem_req);
    end
    force_ack = 1'b0;
    tick;
  endtask

  task automatic test_load_then_fetch;
    int n;
    lat = 1;
    dm_addr = 32'h700;
    dm_we = 1'b0;
    dm_req = 1'b1;
    push(1'b1, mdata(32'h700));
    n = 0;
    do begin
      tick;
      n++;
    end while (dm_ready !== 1'b1 && n < 12);
    total++;
    if (dm_ready !== 1'b1 || n != 3) begin
      bad++;
      $display("FAIL load_latency: dm_ready=%0b after %0d cycles, expected 1 after 3", dm_ready, n);
    end
    dm_req = 1'b0;
    if_addr = 32'h800;
    if_req = 1'b1;
    push(1'b0, mdata(32'h800));
    n = 0;
    do begin
      tick;
      n++;
    end while (if_ready !== 1'b1 && n < 12);
    total++;
    if (if_ready !== 1'b1 || n != 4) begin
      bad++;
      $display("FAIL fetch_latency: if_ready=%0b after %0d cycles, expected 1 after 4", if_ready, n);
    end
    total++;
    if (dm_rdata !== mdata(32'h700) || if_rdata !== mdata(32'h800)) begin
      bad++;
      $display("FAIL rdata_hold: dm_rdata=%h if_rdata=%h, expected %h %h", dm_rdata, if_rdata, mdata(32'h700), mdata(32'h800));
    end
    if_req = 1'b0;
    tick;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    if_kill = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    dm_ctrl = '0;
    last_if = '0;
    test_reset;
    test_single_fetch;
    test_store;
    test_streak;
    test_kill;
    test_reset_mid;
    test_load_then_fetch;
    repeat (3) tick;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d completions outstanding, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-access (MEM) port. Each requester holds a request until it sees a one-cycle ready pulse; the pipeline uses the missing ready as its stall condition. Data accesses have priority, with a bounded-starvation guarantee for fetch. The block also handles IF-side kills caused by branch flushes.

## Interface
- MAX_DATA_STREAK, 4: max consecutive data grants while a fetch is pending (≥1).
- STREAK_W, 3: width of streak counter; must hold MAX_DATA_STREAK.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready or if_kill.
- if_addr  in  32  fetch byte address (word-aligned).
- if_kill  in  1  cancel current/pending fetch (pipeline flush).
- if_ready  out  1  one-cycle pulse; fetch complete, if_rdata valid this cycle.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  data request; dm_we/addr/wdata/ctrl held stable until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_ctrl  in  3  access size/sign code, passed through unchanged.
- dm_ready  out  1  one-cycle pulse; access complete, dm_rdata valid for loads.
- dm_rdata  out  32  load data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ctrl  out  3  access code; fetch always drives word code 3'b000.
- mem_rdata  in  32  memory read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  memory completion; any latency ≥0 cycles after mem_req rises.
- busy  out  1  state ≠ IDLE.
- grant_dm  out  1  current/last grant owner: 1 = data, 0 = fetch.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - No request: stay.
  - Only one of dm_req or (if_req & ~if_kill) high: grant it.
  - Both high: grant data, unless streak == MAX_DATA_STREAK, then grant fetch.
  - On grant: register mem_addr/we/wdata/ctrl from the winner, set mem_req=1, go to WAIT.
  - Fetch grant forces mem_we=0 and mem_ctrl=3'b000.
- WAIT:
  - mem_req and the mem_* fields are held stable.
  - On mem_ack: capture mem_rdata into the owner's rdata register, drop mem_req, go to DONE.
  - if_kill during WAIT on a fetch grant sets a sticky killed flag. The memory transaction still completes, but if_ready is suppressed and if_rdata is not updated.
  - if_kill has no effect on a data grant.
- DONE:
  - Pulse the owner's ready unless the killed flag is set.
  - Clear the killed flag and go to IDLE.
- Requester side:
  - A req seen in IDLE is always a new transaction.
  - A requester presents its next access in the cycle after ready, or deasserts req.
- Streak counter:
  - Data grant while if_req & ~if_kill: increment, saturating at MAX_DATA_STREAK.
  - Fetch grant: clear to 0.
  - Data grant with no pending fetch: clear to 0.
- rdata registers hold their value until the next completed transaction for the same port.
- Reset sets state IDLE and clears the streak and killed flag.
- Reset clears mem_req, mem_we, mem_addr, mem_wdata, mem_ctrl, if_ready, dm_ready, if_rdata, dm_rdata, busy and grant_dm to 0.
- Reset mid-WAIT abandons the transaction; the memory model must tolerate mem_req dropping.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: mem_req=1 (WAIT).
- Cycle 1+L: first cycle with mem_ack=1 (L≥0).
- Cycle 2+L: DONE, ready=1, rdata valid.
- Cycle 3+L: IDLE, next arbitration.
- Minimum is 3 cycles per transaction (L=0); there is no request pipelining.
- mem_ack is ignored when not in WAIT.
- A simultaneous if_kill and mem_ack in WAIT counts as killed.
- if_kill in DONE of a fetch suppresses that cycle's if_ready; if_ready is combinationally gated with ~if_kill.
- if_kill in IDLE blocks the fetch grant that cycle only.

## Test plan
- Single fetch with if_addr=0x0000_0040 and L=0, mem_rdata=0x0000_0093 → mem_req rises at cycle 1. At cycle 2, if_ready=1 and if_rdata=0x0000_0093. mem_we=0 and mem_ctrl=3'b000 throughout.
- Store with dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_ctrl=3'b010, L=3 → mem_* match the inputs and stay stable for cycles 1–4. dm_ready pulses at cycle 5. busy=1 for cycles 1–5.
- dm_req and if_req rise together and are re-presented after each ready, L=0 → grants are D,D,D,D,I,D…. The fetch is granted at the 5th arbitration and the streak resets.
- Fetch in WAIT with L=4 and if_kill pulsed at cycle 2 → the memory transaction completes and if_ready stays 0. if_rdata keeps its prior value. The next IDLE grants the new fetch.
- reset asserted at cycle 2 of a load in WAIT → next cycle all outputs are 0 and state is IDLE. A late mem_ack is ignored; no dm_ready is produced.
- Load followed by fetch, both L=1 → dm_rdata is preserved when the fetch completes. Each ready is exactly one cycle wide.
